// File: rtl/tdpram_pkg.sv
// Shared definitions for the byte-strobed true dual-port RAM (tdpram_be).
// Holds the address-width helper, the byte width, write-priority encodings and the byte parity helper.
package tdpram_pkg;

    localparam int   BYTE_W = 8;
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    // Number of bits needed to hold value (at least one).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 32'sd0;
        while (v > 32'sd0) begin
            n = n + 32'sd1;
            v = v / 32'sd2;
        end
        if (n == 32'sd0) begin
            n = 32'sd1;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Even-parity bit of one byte: stored so that byte ^ bit == 0.
    function automatic logic even_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tdpram_rd_pipe.sv
// Per-port read pipeline: read-valid shift, optional output register stage and parity-error alignment.
// Parity checking is present only when TDPRAM_PARITY_EN is defined.
module tdpram_rd_pipe
    import tdpram_pkg::*;
#(
    parameter int DW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [DW-1:0] rd_data,
`ifdef TDPRAM_PARITY_EN
    input  logic [DW/BYTE_W-1:0] rd_par,
    output logic          perr,
`endif
    output logic [DW-1:0] dout,
    output logic          rvalid
);

    logic          v1_r;
    logic [DW-1:0] d1_r;
    logic          p1_s;
    logic          p1_r;

`ifdef TDPRAM_PARITY_EN
    localparam int NB = DW / BYTE_W;

    // Any byte whose stored parity disagrees with its data flags the whole word.
    always_comb begin
        p1_s = 1'b0;
        for (int k = 0; k < NB; k++) begin
            p1_s = p1_s | (even_par(rd_data[k*BYTE_W +: BYTE_W]) ^ rd_par[k]);
        end
    end
`else
    assign p1_s = 1'b0;
`endif

    // First stage: capture the array word for accepted reads, hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            d1_r <= {DW{1'b0}};
            p1_r <= 1'b0;
        end else begin
            v1_r <= rd_req;
            p1_r <= rd_req & p1_s;
            if (rd_req) begin
                d1_r <= rd_data;
            end else begin
                d1_r <= d1_r;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic          v2_r;
        logic [DW-1:0] d2_r;
        logic          p2_r;

        // Second stage: a reset here drops whatever is still in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                v2_r <= 1'b0;
                d2_r <= {DW{1'b0}};
                p2_r <= 1'b0;
            end else begin
                v2_r <= v1_r;
                p2_r <= p1_r;
                if (v1_r) begin
                    d2_r <= d1_r;
                end else begin
                    d2_r <= d2_r;
                end
            end
        end

        assign dout   = d2_r;
        assign rvalid = v2_r;
`ifdef TDPRAM_PARITY_EN
        assign perr   = p2_r;
`else
        logic unused_p2_s;
        assign unused_p2_s = p2_r;
`endif
    end else begin : g_noreg
        assign dout   = d1_r;
        assign rvalid = v1_r;
`ifdef TDPRAM_PARITY_EN
        assign perr   = p1_r;
`else
        logic unused_p1_s;
        assign unused_p1_s = p1_r;
`endif
    end

endmodule

// File: rtl/tdpram_be.sv
// True dual-port RAM with per-byte write strobes, read-first cross-port behaviour and same-address write merge.
// Optional per-byte parity storage and checking is enabled by defining TDPRAM_PARITY_EN.
module tdpram_be
    import tdpram_pkg::*;
#(
    parameter int    DATA_BYTES = 4,
    parameter int    RAM_DEPTH  = 2048,
    parameter int    OUT_REG    = 0,
    parameter string WR_PRIO    = "B",
    parameter string INIT_FILE  = "",
    localparam int   AW         = clogb2(RAM_DEPTH - 1),
    localparam int   DW         = BYTE_W * DATA_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DATA_BYTES-1:0] a_wem,
    input  logic [AW-1:0]         a_addr,
    input  logic [DW-1:0]         a_din,
`ifdef TDPRAM_PARITY_EN
    input  logic                  a_pinj,
    output logic                  a_perr,
`endif
    output logic [DW-1:0]         a_dout,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [DATA_BYTES-1:0] b_wem,
    input  logic [AW-1:0]         b_addr,
    input  logic [DW-1:0]         b_din,
`ifdef TDPRAM_PARITY_EN
    input  logic                  b_pinj,
    output logic                  b_perr,
`endif
    output logic [DW-1:0]         b_dout,
    output logic                  b_rvalid,
    output logic                  coll
);

    localparam logic PRIO = (WR_PRIO == "A") ? PRIO_A : PRIO_B;

    logic [DW-1:0]         mem_r [0:RAM_DEPTH-1];
    logic                  a_wr_s, b_wr_s, a_rd_s, b_rd_s;
    logic                  same_s;
    logic [DATA_BYTES-1:0] ovl_s, a_wem_s, b_wem_s;
    logic [DW-1:0]         a_rdata_s, b_rdata_s;
    logic                  coll_r;

    // Access decode; reset masks every enable so nothing is read or written.
    always_comb begin
        a_wr_s = a_en & a_we & ~rst;
        b_wr_s = b_en & b_we & ~rst;
        a_rd_s = a_en & ~a_we & ~rst;
        b_rd_s = b_en & ~b_we & ~rst;
    end

    // Same-address dual write: overlapping bytes are taken away from the losing port.
    always_comb begin
        same_s  = a_wr_s & b_wr_s & (a_addr == b_addr);
        ovl_s   = a_wem & b_wem & {DATA_BYTES{same_s}};
        a_wem_s = a_wem;
        b_wem_s = b_wem;
        if (PRIO == PRIO_B) begin
            a_wem_s = a_wem & ~ovl_s;
        end else begin
            b_wem_s = b_wem & ~ovl_s;
        end
    end

    // Byte-wise array update; after the merge no byte is written by both ports.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (a_wr_s && a_wem_s[k]) begin
                mem_r[a_addr][k*BYTE_W +: BYTE_W] <= a_din[k*BYTE_W +: BYTE_W];
            end
            if (b_wr_s && b_wem_s[k]) begin
                mem_r[b_addr][k*BYTE_W +: BYTE_W] <= b_din[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Reads sample the pre-edge array, which gives read-first on a cross-port write.
    assign a_rdata_s = mem_r[a_addr];
    assign b_rdata_s = mem_r[b_addr];

    // Collision flag follows the merging write by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_r <= 1'b0;
        end else begin
            coll_r <= |ovl_s;
        end
    end

    assign coll = coll_r;

`ifdef TDPRAM_PARITY_EN
    logic [DATA_BYTES-1:0] par_r [0:RAM_DEPTH-1];

    // Parity bits travel with their bytes; injection inverts them for every strobed byte.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (a_wr_s && a_wem_s[k]) begin
                par_r[a_addr][k] <= even_par(a_din[k*BYTE_W +: BYTE_W]) ^ a_pinj;
            end
            if (b_wr_s && b_wem_s[k]) begin
                par_r[b_addr][k] <= even_par(b_din[k*BYTE_W +: BYTE_W]) ^ b_pinj;
            end
        end
    end
`endif

    tdpram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_a_pipe (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (a_rd_s),
        .rd_data (a_rdata_s),
`ifdef TDPRAM_PARITY_EN
        .rd_par  (par_r[a_addr]),
        .perr    (a_perr),
`endif
        .dout    (a_dout),
        .rvalid  (a_rvalid)
    );

    tdpram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_b_pipe (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (b_rd_s),
        .rd_data (b_rdata_s),
`ifdef TDPRAM_PARITY_EN
        .rd_par  (par_r[b_addr]),
        .perr    (b_perr),
`endif
        .dout    (b_dout),
        .rvalid  (b_rvalid)
    );

endmodule

// File: tb/tb_tdpram_be.sv
// Bench for tdpram_be: two instances (OUT_REG=0 and OUT_REG=1) share one stimulus table;
// expected reads are queued at issue and matched when each instance should deliver them.
module tb_tdpram_be;

    localparam int DB = 4;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_en, a_we, b_en, b_we;
    logic [DB-1:0] a_wem, b_wem;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [DW-1:0] a_dout [2];
    logic [DW-1:0] b_dout [2];
    logic          a_rv [2];
    logic          b_rv [2];
    logic          coll [2];
`ifdef TDPRAM_PARITY_EN
    logic          a_pinj, b_pinj;
    logic          a_perr [2];
    logic          b_perr [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tdpram_be #(
            .DATA_BYTES(DB), .RAM_DEPTH(2048), .OUT_REG(g), .WR_PRIO("B"), .INIT_FILE("")
        ) dut (
            .clk(clk), .rst(rst),
            .a_en(a_en), .a_we(a_we), .a_wem(a_wem), .a_addr(a_addr), .a_din(a_din),
`ifdef TDPRAM_PARITY_EN
            .a_pinj(a_pinj), .a_perr(a_perr[g]),
`endif
            .a_dout(a_dout[g]), .a_rvalid(a_rv[g]),
            .b_en(b_en), .b_we(b_we), .b_wem(b_wem), .b_addr(b_addr), .b_din(b_din),
`ifdef TDPRAM_PARITY_EN
            .b_pinj(b_pinj), .b_perr(b_perr[g]),
`endif
            .b_dout(b_dout[g]), .b_rvalid(b_rv[g]),
            .coll(coll[g])
        );
    end

    typedef struct {
        logic          rst;
        logic          a_en, a_we, a_pinj;
        logic [DB-1:0] a_wem;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_din, a_exp;
        logic          a_pexp;
        logic          b_en, b_we, b_pinj;
        logic [DB-1:0] b_wem;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_din, b_exp;
        logic          b_pexp;
        logic          cexp;
    } vec_t;

    typedef struct {
        int            due;
        int            inst;
        int            port;
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t          sb [$];
    vec_t          tbl [$];
    logic [DW-1:0] hold [2][2];
    int            edge_n   = 0;
    int            checks   = 0;
    int            failures = 0;

    function automatic vec_t mk(
        input logic rst,
        input logic ae, input logic awe, input logic [DB-1:0] awem, input int aaddr,
        input logic [DW-1:0] adin, input logic [DW-1:0] aexp,
        input logic be, input logic bwe, input logic [DB-1:0] bwem, input int baddr,
        input logic [DW-1:0] bdin, input logic [DW-1:0] bexp,
        input logic cexp);
        vec_t v;
        v = '{default: '0};
        v.rst = rst;
        v.a_en = ae; v.a_we = awe; v.a_wem = awem; v.a_addr = AW'(aaddr); v.a_din = adin; v.a_exp = aexp;
        v.b_en = be; v.b_we = bwe; v.b_wem = bwem; v.b_addr = AW'(baddr); v.b_din = bdin; v.b_exp = bexp;
        v.cexp = cexp;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        logic found;
        int   idx;
        logic act_rv, exp_perr;
        logic [DW-1:0] act_d;
        edge_n++;
        rst = v.rst;
        a_en = v.a_en; a_we = v.a_we; a_wem = v.a_wem; a_addr = v.a_addr; a_din = v.a_din;
        b_en = v.b_en; b_we = v.b_we; b_wem = v.b_wem; b_addr = v.b_addr; b_din = v.b_din;
`ifdef TDPRAM_PARITY_EN
        a_pinj = v.a_pinj; b_pinj = v.b_pinj;
`endif
        for (int g = 0; g < 2; g++) begin
            if (!v.rst && v.a_en && !v.a_we) sb.push_back('{edge_n + g, g, 0, v.a_exp, v.a_pexp});
            if (!v.rst && v.b_en && !v.b_we) sb.push_back('{edge_n + g, g, 1, v.b_exp, v.b_pexp});
        end
        // A reset on this edge drops reads that would have surfaced on it.
        if (v.rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == edge_n) sb.delete(i);
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) begin
                found = 1'b0;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (!found && sb[i].due == edge_n && sb[i].inst == g && sb[i].port == p) begin
                        found = 1'b1;
                        idx = i;
                    end
                end
                exp_perr = 1'b0;
                if (found) begin
                    e = sb[idx];
                    sb.delete(idx);
                    hold[g][p] = e.data;
                    exp_perr = e.perr;
                end else if (v.rst) begin
                    hold[g][p] = 32'h0;
                end
                act_rv = (p == 0) ? a_rv[g] : b_rv[g];
                act_d  = (p == 0) ? a_dout[g] : b_dout[g];
                chk($sformatf("rvalid_o%0d_p%0d", g, p), {31'h0, act_rv}, {31'h0, found});
                chk($sformatf("dout_o%0d_p%0d", g, p), act_d, hold[g][p]);
`ifdef TDPRAM_PARITY_EN
                chk($sformatf("perr_o%0d_p%0d", g, p), {31'h0, (p == 0) ? a_perr[g] : b_perr[g]}, {31'h0, exp_perr});
`else
                if (exp_perr) chk($sformatf("perr_o%0d_p%0d", g, p), 32'h0, 32'h1);
`endif
            end
            chk($sformatf("coll_o%0d", g), {31'h0, coll[g]}, {31'h0, v.cexp});
        end
    endtask

    initial begin
        vec_t v;
        hold = '{default: '0};
        // Power-up reset, write 1, then a reset with enables active must not touch mem[1].
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 1, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'hF, 1, 32'h0BAD0BAD, 32'h0, 1'b1, 1'b0, 4'h0, 1, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'hF, 1, 32'h0BAD0BAD, 32'h0, 1'b1, 1'b0, 4'h0, 1, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 1, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0, 1, 32'h0, 32'hCAFEF00D, 1'b0));
        // Byte-strobed write.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 5, 32'h11223344, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'h8, 5, 32'hAA000000, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 5, 32'h0, 32'hAA223344, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        // Cross-port read-first.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 9, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 9, 32'h0, 32'h0, 1'b1, 1'b1, 4'hF, 9, 32'hDEADBEEF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 9, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        // Collisions: different addresses, partial overlap, no-op strobe, disjoint same-address, full overlap.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 3, 32'h0, 32'h0, 1'b1, 1'b1, 4'hF, 4, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'h3, 3, 32'h11111111, 32'h0, 1'b1, 1'b1, 4'h6, 3, 32'h22222222, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 3, 32'h0, 32'h00222211, 1'b1, 1'b0, 4'h0, 4, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'h0, 3, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 4'hF, 7, 32'h12345678, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 3, 32'h0, 32'h00222211, 1'b1, 1'b0, 4'h0, 7, 32'h0, 32'h12345678, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'h8, 3, 32'hAAAAAAAA, 32'h0, 1'b1, 1'b1, 4'h1, 3, 32'hBBBBBBBB, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 3, 32'h0, 32'hAA2222BB, 1'b1, 1'b0, 4'h0, 3, 32'h0, 32'hAA2222BB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 6, 32'h11111111, 32'h0, 1'b1, 1'b1, 4'hF, 6, 32'h22222222, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 6, 32'h0, 32'h22222222, 1'b0));
        tbl.push_back(idle());

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Back-to-back reads of 0..7 on both ports.
        for (int i = 0; i < 8; i++)
            step(mk(1'b0, 1'b1, 1'b1, 4'hF, i, 32'hA5A50000 | 32'(i), 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 8; i++)
            step(mk(1'b0, 1'b1, 1'b0, 4'h0, i, 32'h0, 32'hA5A50000 | 32'(i), 1'b1, 1'b0, 4'h0, i, 32'h0, 32'hA5A50000 | 32'(i), 1'b0));
        step(idle());
        step(idle());
        // Same stream with reset in cycle 4: the in-flight read is dropped.
        for (int i = 0; i < 8; i++)
            step(mk((i == 4) ? 1'b1 : 1'b0, 1'b1, 1'b0, 4'h0, i, 32'h0, 32'hA5A50000 | 32'(i), 1'b1, 1'b0, 4'h0, i, 32'h0, 32'hA5A50000 | 32'(i), 1'b0));
        step(idle());
        step(idle());

`ifdef TDPRAM_PARITY_EN
        v = mk(1'b0, 1'b1, 1'b1, 4'h1, 2, 32'h0000005A, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0);
        v.a_pinj = 1'b1;
        step(v);
        v = mk(1'b0, 1'b1, 1'b0, 4'h0, 2, 32'h0, 32'hA5A5005A, 1'b1, 1'b0, 4'h0, 2, 32'h0, 32'hA5A5005A, 1'b0);
        v.a_pexp = 1'b1;
        v.b_pexp = 1'b1;
        step(v);
        step(mk(1'b0, 1'b1, 1'b1, 4'h1, 2, 32'h0000005A, 32'h0, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
        step(mk(1'b0, 1'b1, 1'b0, 4'h0, 2, 32'h0, 32'hA5A5005A, 1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0));
`else
        v = idle();
        step(v);
`endif
        step(idle());
        step(idle());
        step(idle());
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
